// File: rtl/cla_pipe_adder_pkg.sv
// ============================================================================
// Module : cla_pkg
// Brief  : Shared constants and sizing helper for the pipelined CLA adder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cla_pkg;

    localparam logic MODE_ADD        = 1'b0;
    localparam logic MODE_SUB        = 1'b1;
    localparam int   CLA_BLK_DEFAULT = 4;

    // Number of register stages; each stage finishes BLK*BPS result bits.
    function automatic int nstg(input int width, input int blk, input int bps);
        return width / (blk * bps);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cla_pipe_adder_if.sv
// ============================================================================
// Module : cla_pipe_adder_if
// Brief  : Operand/result streaming bundle for cla_pipe_adder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );

endinterface

`default_nettype wire

// File: rtl/cla_pipe_adder_block.sv
// ============================================================================
// Module : cla_block
// Brief  : Combinational BLK-bit carry-lookahead block with group G/P outputs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cla_block
    import cla_pkg::*;
#(
    parameter int BLK = CLA_BLK_DEFAULT
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           ci,
    output logic [BLK-1:0] s,
    output logic           co,
    output logic           G,
    output logic           P
);

    logic [BLK-1:0] gen;
    logic [BLK-1:0] prop;
    logic [BLK:0]   c;
    logic           run;
    logic           gk;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Each carry is the flat sum-of-products over the generates below it,
    // so no carry depends on another carry inside the block.
    always_comb begin
        c    = '0;
        c[0] = ci;
        run  = 1'b1;
        gk   = 1'b0;
        for (int i = 0; i < BLK; i++) begin
            run = 1'b1;
            gk  = gen[i];
            for (int j = i; j >= 1; j--) begin
                run = run & prop[j];
                gk  = gk | (run & gen[j-1]);
            end
            c[i+1] = gk | (run & prop[0] & ci);
        end
        G = gk;
    end

    assign P  = &prop;
    assign s  = prop ^ c[BLK-1:0];
    assign co = c[BLK];

endmodule

`default_nettype wire

// File: rtl/cla_pipe_adder.sv
// ============================================================================
// Module : cla_pipe_adder
// Brief  : Pipelined carry-lookahead adder/subtractor with valid/ready streams.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int BLK         = CLA_BLK_DEFAULT,
    parameter int BLK_PER_STG = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    cla_pipe_adder_if.slave  bus
);

    localparam int SW   = BLK * BLK_PER_STG;
    localparam int NSTG = nstg(WIDTH, BLK, BLK_PER_STG);

    if ((WIDTH % SW) != 0 || NSTG < 1) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH must be a nonzero multiple of BLK*BLK_PER_STG");
    end

    logic en;

    assign en          = bus.out_ready || !bus.out_valid;
    assign bus.in_ready = en;

    // Stage k owns result bits [k*SW +: SW]; operands above it ride along
    // and finished low sum bits accumulate below it.
    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int REM = WIDTH - k * SW;

        logic [REM-1:0]          a_in;
        logic [REM-1:0]          b_in;
        logic                    c_in;
        logic                    v_in;
        logic [SW-1:0]           s_slc;
        logic [(k+1)*SW-1:0]     s_cat;
        logic [BLK_PER_STG:0]    carry;
        logic [BLK_PER_STG-1:0]  co_blk;
        logic [BLK_PER_STG-1:0]  grp_g;
        logic [BLK_PER_STG-1:0]  grp_p;
        logic                    v_r;
        logic                    c_r;
        logic [(k+1)*SW-1:0]     s_r;

        if (k == 0) begin : g_head
            assign a_in  = bus.a;
            assign b_in  = (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
            assign c_in  = (bus.sub == MODE_SUB) ? 1'b1 : bus.cin;
            assign v_in  = bus.in_valid;
            assign s_cat = s_slc;
        end else begin : g_body
            assign a_in  = g_stg[k-1].g_fwd.a_r;
            assign b_in  = g_stg[k-1].g_fwd.b_r;
            assign c_in  = g_stg[k-1].c_r;
            assign v_in  = g_stg[k-1].v_r;
            assign s_cat = {s_slc, g_stg[k-1].s_r};
        end

        assign carry[0] = c_in;

        for (genvar j = 0; j < BLK_PER_STG; j++) begin : g_blk
            cla_block #(
                .BLK (BLK)
            ) u_blk (
                .a  (a_in[j*BLK +: BLK]),
                .b  (b_in[j*BLK +: BLK]),
                .ci (carry[j]),
                .s  (s_slc[j*BLK +: BLK]),
                .co (co_blk[j]),
                .G  (grp_g[j]),
                .P  (grp_p[j])
            );
            assign carry[j+1] = grp_g[j] | (grp_p[j] & carry[j]);
        end

        // Block ripple-out and group lookahead must always agree.
        a_carry_consistent: assert property (
            @(posedge clk) disable iff (!rst_n) co_blk == carry[BLK_PER_STG:1]
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                s_r <= '0;
            end else if (en) begin
                v_r <= v_in;
                c_r <= carry[BLK_PER_STG];
                s_r <= s_cat;
            end
        end

        if (k < NSTG - 1) begin : g_fwd
            logic [REM-SW-1:0] a_r;
            logic [REM-SW-1:0] b_r;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (en) begin
                    a_r <= a_in[REM-1:SW];
                    b_r <= b_in[REM-1:SW];
                end
            end
        end else begin : g_tail
            logic ovf_r;
            logic zero_r;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_r  <= 1'b0;
                    zero_r <= 1'b0;
                end else if (en) begin
                    ovf_r  <= (a_in[REM-1] == b_in[REM-1]) && (s_slc[SW-1] != a_in[REM-1]);
                    zero_r <= ~|s_cat;
                end
            end
        end
    end

    assign bus.out_valid = g_stg[NSTG-1].v_r;
    assign bus.sum       = g_stg[NSTG-1].s_r;
    assign bus.cout      = g_stg[NSTG-1].c_r;
    assign bus.ovf       = g_stg[NSTG-1].g_tail.ovf_r;
    assign bus.zero      = g_stg[NSTG-1].g_tail.zero_r;

endmodule

`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
// ============================================================================
// Module : tb_cla_pipe_adder
// Brief  : Self-checking bench for a 16-bit and a 4-bit cla_pipe_adder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cla_pipe_adder;
    import cla_pkg::*;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    cla_pipe_adder_if #(.WIDTH(16)) bus16 ();
    cla_pipe_adder_if #(.WIDTH(4))  bus4 ();

    cla_pipe_adder #(.WIDTH(16), .BLK(4), .BLK_PER_STG(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    cla_pipe_adder #(.WIDTH(4), .BLK(4), .BLK_PER_STG(1)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    typedef struct packed {
        logic [15:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } exp_t;

    // Plain integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        longint full, half, ua, ub, sa, sb, r, sr;
        exp_t   e;
        full = longint'(1) << w;
        half = full / 2;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = (ua >= half) ? ua - full : ua;
        sb   = (ub >= half) ? ub - full : ub;
        if (sub == MODE_SUB) begin
            r    = ua - ub;
            sr   = sa - sb;
            e.co = (ua >= ub);
        end else begin
            r    = ua + ub + longint'(cin);
            sr   = sa + sb + longint'(cin);
            e.co = (r >= full);
        end
        r    = r & (full - 1);
        e.s  = 16'(r);
        e.z  = (r == 0);
        e.ov = (sr < -half) || (sr >= half);
        return e;
    endfunction

    task automatic drive_idle();
        bus16.in_valid  = 1'b0;
        bus16.a         = '0;
        bus16.b         = '0;
        bus16.cin       = 1'b0;
        bus16.sub       = MODE_ADD;
        bus16.out_ready = 1'b1;
        bus4.in_valid   = 1'b0;
        bus4.a          = '0;
        bus4.b          = '0;
        bus4.cin        = 1'b0;
        bus4.sub        = MODE_ADD;
        bus4.out_ready  = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (bus16.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus16.out_valid); end
        total++;
        if (bus16.sum !== 16'h0000) begin bad++; $display("FAIL reset_sum got=%h want=0000", bus16.sum); end
        total++;
        if (bus16.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus16.in_ready); end
        total++;
        if ({bus16.cout, bus16.ovf, bus16.zero} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b want=000", {bus16.cout, bus16.ovf, bus16.zero});
        end
        total++;
        if (bus4.out_valid !== 1'b0 || bus4.sum !== 4'h0) begin
            bad++; $display("FAIL reset_w4 got_valid=%b got_sum=%h want=0/0", bus4.out_valid, bus4.sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            total++;
            if (bus16.out_valid !== 1'b0) begin bad++; $display("FAIL idle_out_valid cycle=%0d got=%b want=0", i, bus16.out_valid); end
        end
    endtask

    task automatic test_single_beat(input string name, input logic [15:0] a, input logic [15:0] b,
                                    input logic cin, input logic sub, input logic [15:0] ws,
                                    input logic wco, input logic wov, input logic wz);
        int cyc;
        @(negedge clk);
        bus16.in_valid  = 1'b1;
        bus16.a         = a;
        bus16.b         = b;
        bus16.cin       = cin;
        bus16.sub       = sub;
        bus16.out_ready = 1'b1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        bus16.in_valid = 1'b0;
        #1;
        while (bus16.out_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            #1;
        end
        total++;
        if (cyc != 4) begin bad++; $display("FAIL %s latency got=%0d want=4", name, cyc); end
        total++;
        if (bus16.sum !== ws) begin bad++; $display("FAIL %s sum got=%h want=%h", name, bus16.sum, ws); end
        total++;
        if ({bus16.cout, bus16.ovf, bus16.zero} !== {wco, wov, wz}) begin
            bad++; $display("FAIL %s flags(cout,ovf,zero) got=%b want=%b", name,
                            {bus16.cout, bus16.ovf, bus16.zero}, {wco, wov, wz});
        end
    endtask

    task automatic test_directed();
        test_single_beat("add_wrap",    16'hFFFF, 16'h0001, 1'b0, MODE_ADD, 16'h0000, 1'b1, 1'b0, 1'b1);
        test_single_beat("add_ovf",     16'h7FFF, 16'h0001, 1'b0, MODE_ADD, 16'h8000, 1'b0, 1'b1, 1'b0);
        test_single_beat("sub_neg",     16'h0003, 16'h0005, 1'b0, MODE_SUB, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        test_single_beat("sub_ovf",     16'h8000, 16'h0001, 1'b0, MODE_SUB, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        test_single_beat("add_cin",     16'h1234, 16'h4321, 1'b1, MODE_ADD, 16'h5556, 1'b0, 1'b0, 1'b0);
        test_single_beat("sub_cin_ign", 16'h0005, 16'h0005, 1'b1, MODE_SUB, 16'h0000, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        exp_t        q[$];
        exp_t        w;
        logic [15:0] va [256];
        logic [15:0] vb [256];
        logic        vc [256];
        logic        vs [256];
        logic [15:0] held_sum;
        int          sent = 0;
        int          got = 0;
        int          cyc = 0;
        int          stall_left = 0;
        int          idx;
        bit          stall_done = 1'b0;
        held_sum = '0;
        for (int i = 0; i < 256; i++) begin
            va[i] = 16'($urandom);
            vb[i] = 16'($urandom);
            vc[i] = 1'($urandom);
            vs[i] = 1'($urandom);
        end
        @(negedge clk);
        while (got < 256 && cyc < 2000) begin
            if (!stall_done && sent == 100) begin
                stall_left = 3;
                stall_done = 1'b1;
            end
            idx = (sent < 256) ? sent : 0;
            bus16.out_ready = (stall_left == 0);
            bus16.in_valid  = (sent < 256);
            bus16.a         = va[idx];
            bus16.b         = vb[idx];
            bus16.cin       = vc[idx];
            bus16.sub       = vs[idx];
            #1;
            total++;
            if (bus16.in_ready !== (stall_left == 0)) begin
                bad++; $display("FAIL in_ready cycle=%0d got=%b want=%b", cyc, bus16.in_ready, (stall_left == 0));
            end
            if (stall_left == 3) begin
                held_sum = bus16.sum;
            end else if (stall_left > 0) begin
                total++;
                if (bus16.out_valid !== 1'b1 || bus16.sum !== held_sum) begin
                    bad++; $display("FAIL stall_hold cycle=%0d got=%b/%h want=1/%h", cyc, bus16.out_valid, bus16.sum, held_sum);
                end
            end
            if (bus16.in_valid && bus16.in_ready) begin
                q.push_back(model(16, va[idx], vb[idx], vc[idx], vs[idx]));
                sent++;
            end
            if (bus16.out_valid && bus16.out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL stream_extra result=%0d got=%h want=none", got, bus16.sum);
                end else begin
                    w = q.pop_front();
                    if ({bus16.sum, bus16.cout, bus16.ovf, bus16.zero} !== {w.s, w.co, w.ov, w.z}) begin
                        bad++; $display("FAIL stream_result n=%0d got=%h/%b%b%b want=%h/%b%b%b", got,
                                        bus16.sum, bus16.cout, bus16.ovf, bus16.zero, w.s, w.co, w.ov, w.z);
                    end
                end
                got++;
            end
            if (stall_left > 0) stall_left--;
            @(negedge clk);
            cyc++;
        end
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        total++;
        if (got != 256 || sent != 256) begin bad++; $display("FAIL stream_count got=%0d sent=%0d want=256", got, sent); end
        got = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (bus16.out_valid === 1'b1) got++;
            @(negedge clk);
        end
        total++;
        if (got != 0) begin bad++; $display("FAIL stream_trailing got=%0d want=0", got); end
    endtask

    task automatic test_exhaustive();
        exp_t     q[$];
        exp_t     w;
        logic [9:0] idx;
        int       sent = 0;
        int       got = 0;
        int       cyc = 0;
        @(negedge clk);
        while (got < 1024 && cyc < 3000) begin
            idx = 10'(sent);
            bus4.in_valid  = (sent < 1024);
            bus4.a         = idx[3:0];
            bus4.b         = idx[7:4];
            bus4.cin       = idx[8];
            bus4.sub       = idx[9];
            bus4.out_ready = 1'b1;
            #1;
            if (bus4.in_valid && bus4.in_ready) begin
                q.push_back(model(4, {12'h000, idx[3:0]}, {12'h000, idx[7:4]}, idx[8], idx[9]));
                sent++;
            end
            if (bus4.out_valid) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL w4_extra got=%h want=none", bus4.sum);
                end else begin
                    w = q.pop_front();
                    if ({bus4.cout, bus4.sum, bus4.ovf, bus4.zero} !== {w.co, w.s[3:0], w.ov, w.z}) begin
                        bad++; $display("FAIL w4_result n=%0d got=%b%h/%b%b want=%b%h/%b%b", got,
                                        bus4.cout, bus4.sum, bus4.ovf, bus4.zero, w.co, w.s[3:0], w.ov, w.z);
                    end
                end
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        bus4.in_valid = 1'b0;
        total++;
        if (got != 1024) begin bad++; $display("FAIL w4_count got=%0d want=1024", got); end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        int seen = 0;
        @(negedge clk);
        bus16.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus16.in_valid = 1'b1;
            bus16.a        = 16'($urandom);
            bus16.b        = 16'($urandom);
            bus16.sub      = 1'($urandom);
            @(negedge clk);
        end
        bus16.in_valid = 1'b0;
        #1;
        while (bus16.out_valid !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
            #1;
        end
        total++;
        if (bus16.out_valid !== 1'b1) begin bad++; $display("FAIL mid_fill got=%b want=1", bus16.out_valid); end
        rst_n = 1'b0;
        #1;
        total++;
        if (bus16.out_valid !== 1'b0 || bus16.sum !== 16'h0000) begin
            bad++; $display("FAIL mid_reset_async got=%b/%h want=0/0000", bus16.out_valid, bus16.sum);
        end
        repeat (2) @(negedge clk);
        rst_n           = 1'b1;
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (bus16.out_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL mid_reset_leak got=%0d want=0", seen); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_exhaustive();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
